// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage: formats stores, extends loads and stalls the pipeline until mem_ack.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses and raises Misalign.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead3,
  input  logic        MemWrite3,
  input  logic [1:0]  Size3,
  input  logic        Unsigned3,
  input  logic [31:0] ALU_out3,
  input  logic [31:0] B3,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] Data_out,
  output logic        Stall,
  output logic        Misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] data_out_q;
  logic        misalign_q;

  logic        access;
  logic        misaligned;
  logic        accept;
  logic [31:0] load_fmt;

  assign access = MemRead3 | MemWrite3;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((Size3 == 2'b01) & ALU_out3[0]) |
                      (Size3[1] & (ALU_out3[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept = access & ~misaligned;

  // Store lane formatting; loads reuse the same byte enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    be_d    = 4'b1111;
    wdata_d = B3;
    case (Size3)
      2'b00: begin
        be_d    = 4'b0001 << ALU_out3[1:0];
        wdata_d = {4{B3[7:0]}};
      end
      2'b01: begin
        be_d    = ALU_out3[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{B3[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)  state_d = BUSY;
      BUSY:    if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select and extension use the captured access, not the live pipeline inputs.
  always_comb begin
    load_fmt = mem_rdata;
    case (size_q)
      2'b00: begin
        logic [7:0] b;
        b        = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        load_fmt = {{24{b[7] & ~unsigned_q}}, b};
      end
      2'b01: begin
        logic [15:0] h;
        h        = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = {{16{h[15] & ~unsigned_q}}, h};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      data_out_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      misalign_q <= (state_q == IDLE) & access & misaligned;
      if (state_q == IDLE && accept) begin
        addr_q     <= ALU_out3;
        be_q       <= be_d;
        wdata_q    <= wdata_d;
        we_q       <= MemWrite3;
        size_q     <= Size3;
        unsigned_q <= Unsigned3;
      end
      if (state_q == BUSY && mem_ack && !we_q) data_out_q <= load_fmt;
    end
  end

  // Stall is forced low during reset even if the pipeline still presents an access.
  assign Stall     = ~rst & (((state_q == IDLE) & accept) | (state_q == BUSY));
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) & we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign Data_out  = data_out_q;
  assign Misalign  = misalign_q;

endmodule
